fetch_stage: RTL

Instruction fetch stage of the five-stage pipeline. It owns the program counter, loads it from the reset vector after reset, and reads 16-bit or 32-bit instructions from instruction memory. It delivers them through the IF/ID pipeline register to decode. It supplies the current PC to the register file's PC write port every cycle and honours stall and redirect requests from downstream stages.

---
 rtl/fetch_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, reset-vector load and IF/ID register
//
// Owns the program counter. After reset it reads a two-word reset vector from
// instruction memory, then fetches 16-bit or 32-bit instructions. A first word
// with bit 15 set has a second word, its immediate. Completed instructions go
// into the IF/ID register.
//
// Ports:
//   clk           single clock, posedge
//   rst           synchronous active-low reset
//   imem_addr     word address to instruction memory (combinational)
//   imem_data     combinational read data for imem_addr
//   stall         hold PC, state, hold registers and IF/ID
//   redirect      replace PC with redirect_pc (beats stall)
//   redirect_pc   redirect target
//   pc_out        registered PC, feeds register file PC write data
//   ifid_valid    IF/ID holds a real instruction (0 = bubble)
//   ifid_instr    first instruction word
//   ifid_imm      second word of a 32-bit instruction, else 0
//   ifid_is32     instruction is 32-bit
//   ifid_pc       PC of the first word
//   ifid_next_pc  PC following the instruction (CALL return address)
module fetch_stage #(
  parameter logic [31:0] RESET_VEC_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic        ifid_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_imm,
  output logic        ifid_is32,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_next_pc
);

  typedef enum logic [1:0] {VEC_LO, VEC_HI, FETCH, IMM} state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [15:0] vec_lo;
  logic [15:0] hold_instr;
  logic [31:0] hold_pc;

  logic do_redirect;
  logic do_issue16;
  logic do_start32;
  logic do_issue32;

  // Wraps modulo 2^32, so an immediate straddling the top of memory comes from 0.
  assign pc_inc = pc + 32'd1;
  assign pc_out = pc;

  always_ff @(posedge clk) begin
    if (!rst) state <= VEC_LO;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    imem_addr   = pc;
    do_redirect = 1'b0;
    do_issue16  = 1'b0;
    do_start32  = 1'b0;
    do_issue32  = 1'b0;
    case (state)
      VEC_LO: begin
        imem_addr  = RESET_VEC_ADDR;
        state_next = VEC_HI;
      end
      VEC_HI: begin
        imem_addr  = RESET_VEC_ADDR + 32'd1;
        state_next = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          do_redirect = 1'b1;
        end else if (!stall) begin
          if (imem_data[15]) begin
            do_start32 = 1'b1;
            state_next = IMM;
          end else begin
            do_issue16 = 1'b1;
          end
        end
      end
      IMM: begin
        // Redirect abandons the held first word by returning to FETCH.
        if (redirect) begin
          do_redirect = 1'b1;
          state_next  = FETCH;
        end else if (!stall) begin
          do_issue32 = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = VEC_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc           <= 32'd0;
      vec_lo       <= 16'd0;
      hold_instr   <= 16'd0;
      hold_pc      <= 32'd0;
      ifid_valid   <= 1'b0;
      ifid_instr   <= 16'd0;
      ifid_imm     <= 16'd0;
      ifid_is32    <= 1'b0;
      ifid_pc      <= 32'd0;
      ifid_next_pc <= 32'd0;
    end else begin
      if (state == VEC_LO) vec_lo <= imem_data;
      if (state == VEC_HI) pc <= {imem_data, vec_lo};

      if (do_redirect) begin
        pc         <= redirect_pc;
        ifid_valid <= 1'b0;
      end

      if (do_issue16) begin
        ifid_valid   <= 1'b1;
        ifid_instr   <= imem_data;
        ifid_imm     <= 16'd0;
        ifid_is32    <= 1'b0;
        ifid_pc      <= pc;
        ifid_next_pc <= pc_inc;
        pc           <= pc_inc;
      end

      // First half of a 32-bit instruction: park it and emit a bubble.
      if (do_start32) begin
        hold_instr <= imem_data;
        hold_pc    <= pc;
        pc         <= pc_inc;
        ifid_valid <= 1'b0;
      end

      if (do_issue32) begin
        ifid_valid   <= 1'b1;
        ifid_instr   <= hold_instr;
        ifid_imm     <= imem_data;
        ifid_is32    <= 1'b1;
        ifid_pc      <= hold_pc;
        ifid_next_pc <= pc_inc;
        pc           <= pc_inc;
      end
    end
  end

endmodule
